// File: rtl/nv_nvdla_hls_shiftrightsu_pipe.sv
// Two-stage pipelined signed arithmetic right shifter with round-half-away-from-zero,
// saturation to OUT_WIDTH, pvld/prdy handshake and a sticky saturation event counter.
module nv_nvdla_hls_shiftrightsu_pipe #(
  parameter int IN_WIDTH    = 32,
  parameter int OUT_WIDTH   = 16,
  parameter int SHIFT_WIDTH = 6,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   nvdla_core_clk,
  input  logic                   nvdla_core_rst,
  input  logic                   in_pvld,
  output logic                   in_prdy,
  input  logic [IN_WIDTH-1:0]    data_in,
  input  logic [SHIFT_WIDTH-1:0] shift_num,
  output logic                   out_pvld,
  input  logic                   out_prdy,
  output logic [OUT_WIDTH-1:0]   data_out,
  output logic                   out_sat,
  input  logic                   sat_clr,
  output logic [CNT_WIDTH-1:0]   sat_cnt
);

  localparam int WW = 2 * IN_WIDTH;
  localparam int HW = IN_WIDTH - OUT_WIDTH + 2;

  logic signed [WW-1:0]  w_wide;
  logic signed [WW-1:0]  w_shifted;
  logic [IN_WIDTH-1:0]   w_floor;
  logic [IN_WIDTH-1:0]   w_frac;
  logic                  w_guide;
  logic                  w_sticky;
  logic                  w_inc;
  logic [IN_WIDTH:0]     w_round;
  logic [HW-1:0]         w_hi;
  logic                  w_fits;
  logic [OUT_WIDTH-1:0]  w_sat_data;
  logic                  w_s2_rdy;
  logic                  w_in_acc;
  logic                  w_out_xfer;

  logic                  r_s1_vld;
  logic [IN_WIDTH:0]     r_s1_data;
  logic                  r_s2_vld;
  logic [OUT_WIDTH-1:0]  r_s2_data;
  logic                  r_s2_sat;
  logic [CNT_WIDTH-1:0]  r_sat_cnt;

  // Shift with an IN_WIDTH-bit fraction window; bits falling below it only matter
  // when they equal the sign, which the window's lower bits already replicate.
  always_comb begin
    w_wide    = {data_in, {IN_WIDTH{1'b0}}};
    w_shifted = w_wide >>> shift_num;
    w_floor   = w_shifted[WW-1:IN_WIDTH];
    w_frac    = w_shifted[IN_WIDTH-1:0];
    w_guide   = w_frac[IN_WIDTH-1];
    w_sticky  = |w_frac[IN_WIDTH-2:0];
    w_inc     = w_guide && (!data_in[IN_WIDTH-1] || w_sticky);
    w_round   = {w_floor[IN_WIDTH-1], w_floor} + {{IN_WIDTH{1'b0}}, w_inc};
  end

  // Clamp the rounded stage-1 value into the signed output range.
  always_comb begin
    w_hi   = r_s1_data[IN_WIDTH:OUT_WIDTH-1];
    w_fits = (&w_hi) || !(|w_hi);
    if (w_fits) begin
      w_sat_data = r_s1_data[OUT_WIDTH-1:0];
    end else if (r_s1_data[IN_WIDTH]) begin
      w_sat_data = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    end else begin
      w_sat_data = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end
  end

  assign w_s2_rdy   = !r_s2_vld || out_prdy;
  assign in_prdy    = !r_s1_vld || w_s2_rdy;
  assign w_in_acc   = in_pvld && in_prdy;
  assign w_out_xfer = r_s2_vld && out_prdy && r_s2_sat;

  // Stage 1: shifted and rounded value.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      r_s1_vld  <= 1'b0;
      r_s1_data <= {(IN_WIDTH+1){1'b0}};
    end else begin
      if (in_prdy) begin
        r_s1_vld <= in_pvld;
      end
      if (w_in_acc) begin
        r_s1_data <= w_round;
      end
    end
  end

  // Stage 2: saturated output beat, held while downstream stalls.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      r_s2_vld  <= 1'b0;
      r_s2_data <= {OUT_WIDTH{1'b0}};
      r_s2_sat  <= 1'b0;
    end else if (w_s2_rdy) begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_data <= w_sat_data;
        r_s2_sat  <= !w_fits;
      end
    end
  end

  // Saturation counter: clear wins, sticks at all-ones.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      r_sat_cnt <= {CNT_WIDTH{1'b0}};
    end else if (sat_clr) begin
      r_sat_cnt <= {CNT_WIDTH{1'b0}};
    end else if (w_out_xfer && !(&r_sat_cnt)) begin
      r_sat_cnt <= r_sat_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign out_pvld = r_s2_vld;
  assign data_out = r_s2_data;
  assign out_sat  = r_s2_sat;
  assign sat_cnt  = r_sat_cnt;

endmodule
